// File: rtl/cpu_run_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_run_pkg
// Description : Shared types and default constants for the CPU run sequencer.
//               Optional feature macro used by this slice: RUN_CTRL_PC_TRACE_EN
// Revision    : 1.0  initial release
// ============================================================================
package cpu_run_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        RUN_IDLE  = 2'd0,
        RUN_RESET = 2'd1,
        RUN_RUN   = 2'd2,
        RUN_DONE  = 2'd3
    } run_state_e;

    // Default parameter values
    localparam int DEF_NUM_CPU    = 1;
    localparam int DEF_PC_W       = 16;
    localparam int DEF_CNT_W      = 16;
    localparam int DEF_RST_CYCLES = 4;

    // Width of a down-counter that is loaded with (cycles-1)
    function automatic int rst_cnt_w(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_run_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_run_ctrl_if
// Description : Control/status bundle between a test harness (master) and the
//               CPU run sequencer (slave). halt_pc is only meaningful when the
//               sequencer is built with RUN_CTRL_PC_TRACE_EN.
// Revision    : 1.0  initial release
// ============================================================================
interface cpu_run_ctrl_if
    import cpu_run_pkg::*;
#(
    parameter int NUM_CPU = DEF_NUM_CPU,
    parameter int PC_W    = DEF_PC_W,
    parameter int CNT_W   = DEF_CNT_W
);
    logic                    start;
    logic                    abort;
    logic [CNT_W-1:0]        budget;
    logic [NUM_CPU-1:0]      cpu_hlt;
    logic [NUM_CPU*PC_W-1:0] cpu_pc;
    logic [NUM_CPU-1:0]      cpu_rst_n;
    logic                    busy;
    logic                    done;
    logic                    timed_out;
    logic [NUM_CPU-1:0]      halt_mask;
    logic [CNT_W-1:0]        cycle_count;
    logic [NUM_CPU*PC_W-1:0] halt_pc;

    modport master (
        output start, abort, budget, cpu_hlt, cpu_pc,
        input  cpu_rst_n, busy, done, timed_out, halt_mask, cycle_count, halt_pc
    );

    modport slave (
        input  start, abort, budget, cpu_hlt, cpu_pc,
        output cpu_rst_n, busy, done, timed_out, halt_mask, cycle_count, halt_pc
    );
endinterface
`default_nettype wire

// File: rtl/run_chan.sv
`default_nettype none
// ============================================================================
// Module      : run_chan
// Description : One core channel of the run sequencer: sticky halt flag and,
//               with RUN_CTRL_PC_TRACE_EN defined, the PC captured at the
//               core's first halt. Without the macro halt_pc_o is tied to 0.
// Revision    : 1.0  initial release
// ============================================================================
module run_chan #(
    parameter int PC_W = 16
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            clr_i,
    input  wire logic            run_i,
    input  wire logic            hlt_i,
    input  wire logic [PC_W-1:0] pc_i,
    output logic                 mask_o,
    output logic                 hit_o,
    output logic [PC_W-1:0]      halt_pc_o
);
    logic mask_q;
    logic w_first;

    // First halt of this core within the current run
    assign w_first = run_i && hlt_i && !mask_q;

    // Sticky halt flag, cleared when a run is armed or aborted
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            mask_q <= 1'b0;
        end else if (w_first) begin
            mask_q <= 1'b1;
        end
    end

    assign mask_o = mask_q;
    // Halted including this cycle's flag, so the FSM can finish on the same edge
    assign hit_o  = mask_q | (run_i & hlt_i);

`ifdef RUN_CTRL_PC_TRACE_EN
    logic [PC_W-1:0] halt_pc_q;

    // Capture the PC only on the first halt so later pulses cannot overwrite it
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            halt_pc_q <= '0;
        end else if (w_first) begin
            halt_pc_q <= pc_i;
        end
    end

    assign halt_pc_o = halt_pc_q;
`else
    logic w_unused_pc;
    assign w_unused_pc = ^pc_i;
    assign halt_pc_o   = '0;
`endif

endmodule
`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cpu_run_ctrl
// Description : Run sequencer for NUM_CPU cores: holds the cores in reset for
//               RST_CYCLES cycles, releases them together, counts run cycles
//               and ends the run on all-halted, budget expiry or abort.
//               Optional macro RUN_CTRL_PC_TRACE_EN enables halt PC capture.
// Revision    : 1.0  initial release
// ============================================================================
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int NUM_CPU    = DEF_NUM_CPU,
    parameter int PC_W       = DEF_PC_W,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int RST_CYCLES = DEF_RST_CYCLES
) (
    input  wire logic     clk,
    input  wire logic     rst,
    cpu_run_ctrl_if.slave bus
);
    localparam int               RC_W      = rst_cnt_w(RST_CYCLES);
    localparam logic [RC_W-1:0]  C_RC_LOAD = RC_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    run_state_e          state_q;
    logic [RC_W-1:0]     rst_cnt_q;
    logic [CNT_W-1:0]    budget_q;
    logic [CNT_W-1:0]    cycle_cnt_q;
    logic [NUM_CPU-1:0]  cpu_rst_n_q;
    logic                busy_q;
    logic                done_q;
    logic                timed_out_q;

    logic                    w_arm;
    logic                    w_clr;
    logic                    w_run;
    logic                    w_all_halt;
    logic                    w_expire;
    logic [NUM_CPU-1:0]      w_mask;
    logic [NUM_CPU-1:0]      w_hit;
    logic [NUM_CPU*PC_W-1:0] w_halt_pc;

    // A start is only honoured from IDLE or DONE, and abort overrides it
    assign w_arm      = bus.start && !bus.abort &&
                        ((state_q == RUN_IDLE) || (state_q == RUN_DONE));
    assign w_clr      = bus.abort || w_arm;
    assign w_run      = (state_q == RUN_RUN);
    assign w_all_halt = &w_hit;
    assign w_expire   = (budget_q != '0) && (cycle_cnt_q == (budget_q - CNT_W'(1)));

    generate
        for (genvar i = 0; i < NUM_CPU; i++) begin : g_chan
            run_chan #(
                .PC_W (PC_W)
            ) u_chan (
                .clk       (clk),
                .rst       (rst),
                .clr_i     (w_clr),
                .run_i     (w_run),
                .hlt_i     (bus.cpu_hlt[i]),
                .pc_i      (bus.cpu_pc[i*PC_W +: PC_W]),
                .mask_o    (w_mask[i]),
                .hit_o     (w_hit[i]),
                .halt_pc_o (w_halt_pc[i*PC_W +: PC_W])
            );
        end
    endgenerate

    // Sequencer FSM with reset down-counter, run counter and status outputs
    always_ff @(posedge clk) begin
        if (rst || bus.abort) begin
            state_q     <= RUN_IDLE;
            rst_cnt_q   <= '0;
            budget_q    <= '0;
            cycle_cnt_q <= '0;
            cpu_rst_n_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            case (state_q)
                RUN_IDLE, RUN_DONE: begin
                    if (bus.start) begin
                        state_q     <= RUN_RESET;
                        budget_q    <= bus.budget;
                        rst_cnt_q   <= C_RC_LOAD;
                        cycle_cnt_q <= '0;
                        cpu_rst_n_q <= '0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        timed_out_q <= 1'b0;
                    end
                end
                RUN_RESET: begin
                    if (rst_cnt_q == '0) begin
                        state_q     <= RUN_RUN;
                        cpu_rst_n_q <= '1;
                    end else begin
                        rst_cnt_q <= rst_cnt_q - RC_W'(1);
                    end
                end
                RUN_RUN: begin
                    // Halt has priority over a simultaneous budget expiry
                    if (w_all_halt) begin
                        state_q     <= RUN_DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        timed_out_q <= 1'b0;
                    end else if (w_expire) begin
                        state_q     <= RUN_DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        timed_out_q <= 1'b1;
                    end else if (cycle_cnt_q != C_CNT_MAX) begin
                        cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= RUN_IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_rst_n   = cpu_rst_n_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.timed_out   = timed_out_q;
    assign bus.halt_mask   = w_mask;
    assign bus.cycle_count = cycle_cnt_q;
    assign bus.halt_pc     = w_halt_pc;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_run_ctrl
// Description : Directed self-checking bench for cpu_run_ctrl with 1-, 2- and
//               4-core instances. Honours RUN_CTRL_PC_TRACE_EN for halt_pc.
// Revision    : 1.0  initial release
// ============================================================================
module tb_cpu_run_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    cpu_run_ctrl_if #(.NUM_CPU(1), .PC_W(16), .CNT_W(16)) if1 ();
    cpu_run_ctrl_if #(.NUM_CPU(2), .PC_W(16), .CNT_W(16)) if2 ();
    cpu_run_ctrl_if #(.NUM_CPU(4), .PC_W(16), .CNT_W(16)) if4 ();

    cpu_run_ctrl #(.NUM_CPU(1), .PC_W(16), .CNT_W(16), .RST_CYCLES(4)) u_dut1 (
        .clk(clk), .rst(rst), .bus(if1));
    cpu_run_ctrl #(.NUM_CPU(2), .PC_W(16), .CNT_W(16), .RST_CYCLES(4)) u_dut2 (
        .clk(clk), .rst(rst), .bus(if2));
    cpu_run_ctrl #(.NUM_CPU(4), .PC_W(16), .CNT_W(16), .RST_CYCLES(4)) u_dut4 (
        .clk(clk), .rst(rst), .bus(if4));

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [63:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL sb_empty observed=%0h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [3:0]  hv;
        logic [3:0]  exp_mask;
        logic [63:0] exp_pc;
        logic [15:0] pcv;

        if1.start = 0; if1.abort = 0; if1.budget = '0; if1.cpu_hlt = '0; if1.cpu_pc = '0;
        if2.start = 0; if2.abort = 0; if2.budget = '0; if2.cpu_hlt = '0; if2.cpu_pc = '0;
        if4.start = 0; if4.abort = 0; if4.budget = '0; if4.cpu_hlt = '0; if4.cpu_pc = '0;

        // ---------------- reset state ----------------
        tick(); tick();
        rst = 1'b0;
        push("rst_dut1", 64'd0);
        chk(64'({if1.cpu_rst_n, if1.busy, if1.done, if1.timed_out, if1.halt_mask, if1.cycle_count, if1.halt_pc}));
        push("rst_dut2", 64'd0);
        chk(64'({if2.cpu_rst_n, if2.busy, if2.done, if2.timed_out, if2.halt_mask, if2.cycle_count, if2.halt_pc}));
        for (int k = 0; k < 20; k++) begin
            push("idle20", 64'd0);
            chk(64'({if4.cpu_rst_n, if4.busy, if4.done, if4.timed_out, if4.halt_mask, if4.cycle_count}));
            tick();
        end
        push("idle_pc4", 64'd0);
        chk(if4.halt_pc);

        // ---------------- A: single core, halt at RUN cycle 10 ----------------
        if1.budget = 16'd0; if1.start = 1; tick(); if1.start = 0;
        n = 0;
        for (int k = 0; k < 20 && if1.cpu_rst_n == 1'b0; k++) begin n++; tick(); end
        push("A_rst_low_cycles", 64'd4);
        chk(64'(n));
        push("A_first_run", 64'({1'b1, 1'b1, 16'd0}));
        chk(64'({if1.busy, if1.cpu_rst_n, if1.cycle_count}));
        for (int c = 0; c < 10; c++) begin
            if1.start  = (c == 3);          // start during RUN must be ignored
            if1.cpu_pc = 16'h0100 + 16'(c);
            tick();
        end
        if1.start = 0;
        push("A_pre_halt", 64'({1'b0, 16'd10}));
        chk(64'({if1.done, if1.cycle_count}));
        if1.cpu_pc = 16'hBEEF; if1.cpu_hlt = 1'b1; tick();
        if1.cpu_hlt = 1'b0; if1.cpu_pc = 16'h0200;
        push("A_done", 64'({1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd10}));
        chk(64'({if1.done, if1.timed_out, if1.busy, if1.cpu_rst_n, if1.halt_mask, if1.cycle_count}));
`ifdef RUN_CTRL_PC_TRACE_EN
        push("A_halt_pc", 64'h0000_0000_0000_BEEF);
`else
        push("A_halt_pc", 64'd0);
`endif
        chk(64'(if1.halt_pc));
        tick(); tick();
        push("A_hold", 64'({1'b1, 1'b1, 16'd10}));
        chk(64'({if1.done, if1.cpu_rst_n, if1.cycle_count}));

        // ---------------- B: four cores halting at 5, 9, 9, 30 ----------------
        if4.budget = 16'd0; if4.start = 1; tick(); if4.start = 0;
        for (int k = 0; k < 20 && if4.cpu_rst_n != 4'hF; k++) tick();
        push("B_released", 64'hF);
        chk(64'(if4.cpu_rst_n));
        exp_mask = 4'h0;
        exp_pc   = '0;
        for (int c = 0; c <= 30; c++) begin
            hv = (c == 5) ? 4'b0001 : (c == 9) ? 4'b0110 :
                 (c == 20) ? 4'b0001 : (c == 30) ? 4'b1000 : 4'b0000;
            for (int i = 0; i < 4; i++) begin
                pcv = 16'(c * 16 + i);
                if4.cpu_pc[i*16 +: 16] = pcv;
                if (hv[i] && !exp_mask[i]) exp_pc[i*16 +: 16] = pcv;
            end
            exp_mask = exp_mask | hv;
            push("B_mask", 64'(exp_mask));
            push("B_done", 64'(exp_mask == 4'hF));
            push("B_count", 64'((c == 30) ? 30 : c + 1));
            if4.cpu_hlt = hv;
            tick();
            if4.cpu_hlt = 4'h0;
            chk(64'(if4.halt_mask));
            chk(64'(if4.done));
            chk(64'(if4.cycle_count));
        end
        push("B_timed_out", 64'd0);
        chk(64'(if4.timed_out));
`ifdef RUN_CTRL_PC_TRACE_EN
        push("B_halt_pc", exp_pc);
`else
        push("B_halt_pc", 64'd0);
`endif
        chk(if4.halt_pc);

        // ---------------- C: two cores, budget 20, core 1 never halts ----------------
        if2.budget = 16'd20; if2.start = 1; tick(); if2.start = 0;
        for (int k = 0; k < 20 && if2.cpu_rst_n != 2'b11; k++) tick();
        n = 0;
        for (int k = 0; k < 100 && !if2.done; k++) begin
            if2.cpu_hlt = (if2.cycle_count == 16'd5) ? 2'b01 : 2'b00;
            if (if2.busy && if2.cpu_rst_n == 2'b11) n++;
            tick();
        end
        if2.cpu_hlt = 2'b00;
        push("C_run_cycles", 64'd20);
        chk(64'(n));
        push("C_status", 64'({1'b1, 1'b1, 2'b01, 16'd19}));
        chk(64'({if2.done, if2.timed_out, if2.halt_mask, if2.cycle_count}));

        // ---------------- D: budget 8, last halt on the expiry cycle ----------------
        if2.budget = 16'd8; if2.start = 1; tick(); if2.start = 0;
        push("D_rearm", 64'({1'b0, 1'b0, 2'b00, 1'b1}));
        chk(64'({if2.done, if2.timed_out, if2.halt_mask, if2.busy}));
        for (int k = 0; k < 20 && if2.cpu_rst_n != 2'b11; k++) tick();
        n = 0;
        for (int k = 0; k < 100 && !if2.done; k++) begin
            if2.cpu_hlt = (if2.cycle_count == 16'd2) ? 2'b01 :
                          (if2.cycle_count == 16'd7) ? 2'b10 : 2'b00;
            if (if2.busy && if2.cpu_rst_n == 2'b11) n++;
            tick();
        end
        if2.cpu_hlt = 2'b00;
        push("D_run_cycles", 64'd8);
        chk(64'(n));
        push("D_status", 64'({1'b1, 1'b0, 2'b11, 16'd7}));
        chk(64'({if2.done, if2.timed_out, if2.halt_mask, if2.cycle_count}));

        // ---------------- E: restart from DONE, abort+start at RUN cycle 3 ----------------
        if4.start = 1; tick(); if4.start = 0;
        push("E_rearm", 64'({1'b1, 1'b0, 4'h0, 16'd0}));
        chk(64'({if4.busy, if4.done, if4.halt_mask, if4.cycle_count}));
        push("E_rearm_pc", 64'd0);
        chk(if4.halt_pc);
        for (int k = 0; k < 20 && if4.cpu_rst_n != 4'hF; k++) tick();
        for (int c = 0; c < 3; c++) begin
            if4.cpu_hlt = (c == 1) ? 4'b0010 : 4'b0000;
            tick();
        end
        if4.cpu_hlt = 4'h0;
        push("E_pre_abort", 64'({4'b0010, 16'd3}));
        chk(64'({if4.halt_mask, if4.cycle_count}));
        if4.abort = 1; if4.start = 1; tick(); if4.abort = 0; if4.start = 0;
        push("E_aborted", 64'd0);
        chk(64'({if4.cpu_rst_n, if4.busy, if4.done, if4.timed_out, if4.halt_mask, if4.cycle_count}));
        push("E_aborted_pc", 64'd0);
        chk(if4.halt_pc);
        tick(); tick(); tick();
        push("E_stay_idle", 64'd0);
        chk(64'({if4.cpu_rst_n, if4.busy, if4.done}));
        if4.start = 1; tick(); if4.start = 0;
        for (int k = 0; k < 20 && if4.cpu_rst_n != 4'hF; k++) tick();
        push("E_rerun_first", 64'({4'hF, 16'd0}));
        chk(64'({if4.cpu_rst_n, if4.cycle_count}));
        tick(); tick();
        if4.cpu_hlt = 4'hF; tick(); if4.cpu_hlt = 4'h0;
        push("E_rerun_done", 64'({1'b1, 1'b0, 4'hF, 16'd2}));
        chk(64'({if4.done, if4.timed_out, if4.halt_mask, if4.cycle_count}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
